rom_loader: RTL and testbench

//  Downstream of the sys SPI monitor core: consumes its rom_do/rom_do_valid byte stream while
//  rom_loading is high. Packs bytes little-endian into 16-bit words, buffers them in a small FIFO,
//  and writes them to the game-ROM memory via a req/ack port at sequential word addresses.

---
 rtl/rom_loader_pkg.sv | 17 +
 rtl/rom_loader_fifo.sv | 64 ++++++
 rtl/rom_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_rom_loader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM loader: FSM state encoding,
// byte-enable patterns and the FIFO entry width ({be, data}).
package rom_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] BE_FULL = 2'b11;
  localparam logic [1:0] BE_LOW  = 2'b01;

  localparam int FIFO_W = 18;

endpackage

// File: rtl/rom_loader_fifo.sv
// Synchronous show-ahead FIFO holding {be, data} words for the memory port.
// dout always presents the oldest entry. A push while full is accepted only
// when a pop happens in the same cycle. clr empties the FIFO synchronously.
module rom_loader_fifo
  import rom_loader_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic [FIFO_W-1:0] din,
  input  logic              pop,
  output logic [FIFO_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [FIFO_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; clear wins over any push/pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rom_loader.sv
// ROM loader: packs the sys ROM byte stream little-endian into 16-bit words,
// buffers them in a small FIFO and writes them to sequential word addresses
// over a req/ack port. load_done pulses once every word has been accepted
// after the load window closes.
// Optional feature: define ROM_LOADER_CKSUM_EN to add the cksum output
// (16-bit wrapping sum of accepted bytes of the current load).
//
// Memory handshake: mem_req, mem_addr, mem_wdata and mem_be are registered and
// held stable while mem_req is high; a request completes in the cycle mem_ack
// is sampled high, after which mem_req is low for at least one cycle. mem_ack
// while mem_req is low has no effect.
//
// A byte that arrives while the FIFO is full (and no pop frees a slot that
// cycle) is dropped whole: it is neither counted nor packed, and overflow is set.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int          ADDR_W     = 22,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rom_loading,
  input  logic [7:0]        rom_do,
  input  logic              rom_do_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   byte_count,
  output logic              overflow,
  output logic              load_done,
  output logic              busy,
  output state_t            dbg_state
`ifdef ROM_LOADER_CKSUM_EN
  ,
  output logic [15:0]       cksum
`endif
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t              state_q, state_d;
  logic                loading_q;
  logic                pend_q, pend_d;
  logic                half_q, half_d;
  logic [7:0]          low_q, low_d;
  logic [ADDR_W:0]     byte_count_q, byte_count_d;
  logic                overflow_q, overflow_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [1:0]          be_q, be_d;
`ifdef ROM_LOADER_CKSUM_EN
  logic [15:0]         cksum_q, cksum_d;
`endif

  logic                rise;
  logic                start;
  logic                fifo_clr;
  logic                fifo_push;
  logic [FIFO_W-1:0]   fifo_din;
  logic                fifo_pop;
  logic [FIFO_W-1:0]   fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                room;

  assign rise     = rom_loading && !loading_q;
  assign fifo_pop = req_q && mem_ack;
  assign room     = !fifo_full || fifo_pop;

  rom_loader_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state logic: FSM, byte packing, counters and memory-port registers.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    half_d       = half_q;
    low_d        = low_q;
    byte_count_d = byte_count_q;
    overflow_d   = overflow_q;
    req_d        = req_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
`ifdef ROM_LOADER_CKSUM_EN
    cksum_d      = cksum_q;
`endif
    start        = 1'b0;
    fifo_clr     = 1'b0;
    fifo_push    = 1'b0;
    fifo_din     = '0;

    // Memory port: complete on ack, otherwise launch the FIFO head.
    if (req_q) begin
      if (mem_ack) begin
        req_d  = 1'b0;
        addr_d = addr_q + ADDR_W'(1);
      end
    end else if ((state_q == ST_LOAD || state_q == ST_FLUSH) && !fifo_empty) begin
      req_d   = 1'b1;
      wdata_d = fifo_dout[15:0];
      be_d    = fifo_dout[17:16];
    end

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          start   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!rom_loading) begin
          // Window closed: flush a pending low byte as a half word.
          state_d = ST_FLUSH;
          half_d  = 1'b0;
          if (half_q) begin
            if (room) begin
              fifo_push = 1'b1;
              fifo_din  = {BE_LOW, 8'h00, low_q};
            end else begin
              overflow_d = 1'b1;
            end
          end
        end else if (rom_do_valid) begin
          if (room) begin
            if (byte_count_q != '1) byte_count_d = byte_count_q + (ADDR_W+1)'(1);
`ifdef ROM_LOADER_CKSUM_EN
            cksum_d = cksum_q + {8'h00, rom_do};
`endif
            if (half_q) begin
              fifo_push = 1'b1;
              fifo_din  = {BE_FULL, rom_do, low_q};
              half_d    = 1'b0;
            end else begin
              low_d  = rom_do;
              half_d = 1'b1;
            end
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (rise) pend_d = 1'b1;
        if (fifo_empty && !req_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        pend_d = 1'b0;
        if (rom_loading || pend_q) begin
          start   = 1'b1;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load start: fresh counters, empty FIFO, address back to base.
    if (start) begin
      fifo_clr     = 1'b1;
      byte_count_d = '0;
      overflow_d   = 1'b0;
      half_d       = 1'b0;
      low_d        = '0;
      addr_d       = BASE;
`ifdef ROM_LOADER_CKSUM_EN
      cksum_d      = '0;
`endif
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      loading_q    <= 1'b0;
      pend_q       <= 1'b0;
      half_q       <= 1'b0;
      low_q        <= '0;
      byte_count_q <= '0;
      overflow_q   <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= BASE;
      wdata_q      <= '0;
      be_q         <= '0;
`ifdef ROM_LOADER_CKSUM_EN
      cksum_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      loading_q    <= rom_loading;
      pend_q       <= pend_d;
      half_q       <= half_d;
      low_q        <= low_d;
      byte_count_q <= byte_count_d;
      overflow_q   <= overflow_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
`ifdef ROM_LOADER_CKSUM_EN
      cksum_q      <= cksum_d;
`endif
    end
  end

  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_be     = be_q;
  assign byte_count = byte_count_q;
  assign overflow   = overflow_q;
  assign load_done  = (state_q == ST_DONE);
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign dbg_state  = state_q;
`ifdef ROM_LOADER_CKSUM_EN
  assign cksum      = cksum_q;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: byte driver tasks, an ack responder, and a scoreboard
// of expected {addr, be, data} writes compared when each write is accepted.
module tb_rom_loader;
  import rom_loader_pkg::*;

  localparam int ADDR_W = 22;
  localparam int W      = ADDR_W + 18;

  logic              clk;
  logic              reset;
  logic              rom_loading;
  logic [7:0]        rom_do;
  logic              rom_do_valid;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_be;
  logic              mem_ack;
  logic [ADDR_W:0]   byte_count;
  logic              overflow;
  logic              load_done;
  logic              busy;
  state_t            dbg_state;
`ifdef ROM_LOADER_CKSUM_EN
  logic [15:0]       cksum;
`endif

  rom_loader #(
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (0),
    .FIFO_DEPTH (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rom_loading  (rom_loading),
    .rom_do       (rom_do),
    .rom_do_valid (rom_do_valid),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ack      (mem_ack),
    .byte_count   (byte_count),
    .overflow     (overflow),
    .load_done    (load_done),
    .busy         (busy),
    .dbg_state    (dbg_state)
`ifdef ROM_LOADER_CKSUM_EN
    ,
    .cksum        (cksum)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(600_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  logic              m_half;
  logic [7:0]        m_low;
  logic [ADDR_W-1:0] m_addr;
  int                m_count;
  logic [15:0]       m_sum;

  bit   ack_en    = 1'b1;
  bit   ack_rand  = 1'b0;
  int   ack_delay = 1;
  int   wait_cnt  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req && ack_en && !reset) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          if (ack_rand) ack_delay = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // ---------------- write monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (mem_req && mem_ack && !reset) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_write", {mem_addr, mem_be, mem_wdata}, '1);
        end else begin
          e = exp_q.pop_front();
          check_val("write", {mem_addr, mem_be, mem_wdata}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_start();
    m_half  = 1'b0;
    m_low   = '0;
    m_addr  = '0;
    m_count = 0;
    m_sum   = '0;
  endtask

  task automatic start_load();
    @(posedge clk);
    #1 rom_loading = 1'b1;
    model_start();
    repeat (2) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit acc, input int gap);
    @(posedge clk);
    #1;
    rom_do       = b;
    rom_do_valid = 1'b1;
    if (acc) begin
      m_count++;
      m_sum = m_sum + {8'h00, b};
      if (m_half) begin
        exp_q.push_back({m_addr, 2'b11, b, m_low});
        m_addr = m_addr + 1'b1;
        m_half = 1'b0;
      end else begin
        m_low  = b;
        m_half = 1'b1;
      end
    end
    @(posedge clk);
    #1 rom_do_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic end_load();
    @(posedge clk);
    #1 rom_loading = 1'b0;
    if (m_half) begin
      exp_q.push_back({m_addr, 2'b01, 8'h00, m_low});
      m_addr = m_addr + 1'b1;
      m_half = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int exp_cnt, input logic exp_ovf);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (load_done) seen = 1'b1;
    end
    check_val({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check_val({tag, "_byte_count"}, 64'(byte_count), 64'(exp_cnt));
      check_val({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
      check_val({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
`ifdef ROM_LOADER_CKSUM_EN
      check_val({tag, "_cksum"}, 64'(cksum), 64'(m_sum));
`endif
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int pulses;
    bit got_req;
    bit in_flush;
    reset        = 1'b1;
    rom_loading  = 1'b0;
    rom_do       = '0;
    rom_do_valid = 1'b0;
    model_start();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_mem_req", 64'(mem_req), 64'd0);
    check_val("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_val("rst_outputs", {overflow, load_done, busy, mem_be, mem_wdata}, 64'd0);
    check_val("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // Bytes outside the load window are ignored.
    send_byte(8'h5A, 1'b0, 1);
    @(negedge clk);
    check_val("idle_byte_ignored", {byte_count, busy, mem_req}, 64'd0);

    // Test 1: four bytes, ack one cycle after req, with write latency check.
    ack_delay = 1;
    start_load();
    send_byte(8'h11, 1'b1, 2);
    send_byte(8'h22, 1'b1, 0);
    @(negedge clk);
    check_val("t1_latency_c1", 64'(mem_req), 64'd0);
    @(negedge clk);
    check_val("t1_latency_c2", 64'(mem_req), 64'd1);
    send_byte(8'h33, 1'b1, 2);
    send_byte(8'h44, 1'b1, 2);
    end_load();
    wait_done("t1", 4, 1'b0);
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (load_done) pulses++;
    end
    check_val("t1_single_pulse", 64'(pulses), 64'd0);
    check_val("t1_idle", 64'(dbg_state), 64'(ST_IDLE));

    // Test 2: odd byte count leaves a half word flushed with be=01.
    start_load();
    send_byte(8'hAA, 1'b1, 1);
    send_byte(8'hBB, 1'b1, 1);
    send_byte(8'hCC, 1'b1, 1);
    end_load();
    wait_done("t2", 3, 1'b0);

    // Test 3: ack held off until the FIFO fills and bytes are dropped.
    ack_en = 1'b0;
    start_load();
    for (int i = 0; i < 20; i++) send_byte(8'(8'h40 + i), (i < 16), 3);
    @(negedge clk);
    check_val("t3_overflow", 64'(overflow), 64'd1);
    check_val("t3_byte_count", 64'(byte_count), 64'd16);
    check_val("t3_req_held", {mem_req, mem_addr}, {1'b1, 22'd0});
    end_load();
    repeat (4) @(posedge clk);
    #1 ack_en = 1'b1;
    wait_done("t3", 16, 1'b1);

    // Test 4: reset while a request is outstanding.
    ack_en = 1'b0;
    start_load();
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b1, 0);
    got_req = 1'b0;
    for (int i = 0; i < 50 && !got_req; i++) begin
      @(negedge clk);
      if (mem_req) got_req = 1'b1;
    end
    check_val("t4_req_seen", 64'(got_req), 64'd1);
    reset = 1'b1;
    #1;
    check_val("t4_req_dropped", 64'(mem_req), 64'd0);
    check_val("t4_addr", 64'(mem_addr), 64'd0);
    check_val("t4_outputs", {byte_count, overflow, load_done, busy, mem_be, mem_wdata}, 64'd0);
    exp_q.delete();
    rom_loading = 1'b0;
    model_start();
    wait_cnt = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    check_val("t4_state_after", 64'(dbg_state), 64'(ST_IDLE));

    // Test 5: rom_loading re-raised during FLUSH starts a second load.
    ack_delay = 3;
    start_load();
    for (int i = 0; i < 4; i++) send_byte(8'(8'h90 + i), 1'b1, 0);
    end_load();
    in_flush = 1'b0;
    for (int i = 0; i < 100 && !in_flush; i++) begin
      @(negedge clk);
      if (dbg_state == ST_FLUSH) in_flush = 1'b1;
    end
    check_val("t5_flush_seen", 64'(in_flush), 64'd1);
    rom_loading = 1'b1;
    wait_done("t5a", 4, 1'b0);
    @(negedge clk);
    check_val("t5_reload_state", 64'(dbg_state), 64'(ST_LOAD));
    check_val("t5_count_restart", 64'(byte_count), 64'd0);
    model_start();
    send_byte(8'hE1, 1'b1, 1);
    send_byte(8'hE2, 1'b1, 1);
    end_load();
    wait_done("t5b", 2, 1'b0);

    // Random stream with random ack delays.
    ack_rand = 1'b1;
    start_load();
    begin
      int n;
      n = $urandom_range(5, 15);
      for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, $urandom_range(1, 3));
      end_load();
      wait_done("rand", n, 1'b0);
    end
    ack_rand  = 1'b0;
    ack_delay = 1;

`ifdef ROM_LOADER_CKSUM_EN
    // Test 6: checksum wraps at 16 bits.
    start_load();
    send_byte(8'hFF, 1'b1, 1);
    send_byte(8'hFF, 1'b1, 1);
    send_byte(8'h02, 1'b1, 1);
    end_load();
    wait_done("t6", 3, 1'b0);
    check_val("t6_cksum_const", 64'(cksum), 64'h0200);
`endif

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
